gps_uart_rx: RTL and testbench
==============================

Name: gps_uart_rx

Overview:
- Serial receive front end for the GPS NMEA path. Sits directly upstream of the GPS sentence parser.
- Samples the module's asynchronous RX pin at 16x oversampling and recovers 8N1 bytes using majority-vote bit decisions.
- Delivers each byte as uart_data with a one-cycle uart_valid strobe, which is exactly the handshake the parser consumes.
- Flags bad stop bits and rejects false start bits.

Parameters:
- CLK_FREQ, 100_000_000: system clock in Hz.
- BAUD, 9600: line rate in bit/s.
- OS_DIV, derived = (CLK_FREQ + BAUD*8) / (BAUD*16): clocks per oversample tick. Must be ≥2; elaboration fails otherwise.

Ports:
- clk  in  1: system clock.
- rst  in  1: reset.
- rx  in  1: asynchronous serial input, idle high.
- uart_data  out  8: last correctly framed byte.
- uart_valid  out  1: one-cycle strobe when uart_data is updated.
- frame_err  out  1: one-cycle strobe when the stop bit is sampled low.
- busy  out  1: high while a frame is in progress (state ≠ IDLE).

Behaviour:
- Clocking and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values:
  - uart_data=0, uart_valid=0, frame_err=0, busy=0.
  - Synchronizer flops=1; state=IDLE; armed=1; all counters 0.
- Input path: rx passes through a 2-flop synchronizer to give rx_s. All decisions use rx_s.
- Tick generator:
  - div_cnt counts 0..OS_DIV-1 and is held at 0 in IDLE.
  - tick is asserted when div_cnt==OS_DIV-1; div_cnt then wraps to 0.
  - os_cnt (4 bits) increments on each tick, 0..15, and wraps.
- Bit decision: sample rx_s on ticks os_cnt=7,8,9. The bit value is the majority of the 3 samples.
- State machine:
  - IDLE: if armed and rx_s==0, go to START and clear div_cnt and os_cnt. If rx_s==1, set armed=1.
  - START:
    - On the tick with os_cnt==9: if majority==1 it is a false start; go to IDLE with no strobe.
    - On the tick with os_cnt==15: go to DATA with bit_idx=0.
  - DATA:
    - On the tick with os_cnt==9: shift the majority bit into shreg, LSB first.
    - On the tick with os_cnt==15: increment bit_idx. After bit_idx 7 completes, go to STOP.
  - STOP, on the tick with os_cnt==9:
    - If majority==1: uart_data<=shreg and uart_valid=1 for one cycle.
    - If majority==0: frame_err=1 for one cycle, uart_data unchanged, armed=0.
    - In both cases go to IDLE. The early exit, 6/16 bit before the nominal stop-bit end, allows back-to-back frames.
- Latency: uart_valid rises 9*16*OS_DIV + 10*OS_DIV clocks after the START entry. START entry is 2–3 clocks after the rx falling edge.
- Strobe exclusivity: uart_valid and frame_err are never high in the same cycle. Both are always single-cycle.
- Break / line stuck low: after a frame error, armed=0 blocks new starts until rx_s is seen high. No repeated frame_err while the line is held low.
- Sampling window: glitches shorter than 1 tick that do not span 2 of the 3 sample instants do not corrupt a bit.
- Reset mid-frame: rst returns the block to IDLE immediately. The partial byte is discarded and no strobe is issued.
- Out of scope: no FIFO and no overrun detection. The consumer must accept one byte per uart_valid, which is guaranteed at ≥1 bit time spacing.

Decomposition:
- Shared package gps_uart_pkg:
  - state enum {IDLE, START, DATA, STOP}.
  - OS_RATE=16, SAMPLE_LO=7, SAMPLE_MID=8, SAMPLE_HI=9, DATA_BITS=8.
  - os_div() function.
- One sub-module: gps_uart_os_tick, containing the div_cnt/tick generator with a synchronous clear input.

Test Plan (CLK_FREQ=1_600_000, BAUD=10_000, so OS_DIV=10 and 160 clocks per bit):
- Single byte: send 0x24 in 8N1 → exactly one uart_valid, uart_data=0x24, frame_err=0. The strobe arrives 1542±2 clocks after the rx falling edge.
- Back-to-back: send "$GPGGA" with zero idle between frames → six uart_valid strobes with uart_data 0x24,0x47,0x50,0x47,0x47,0x41 and no frame_err.
- False start:
  - rx low for 40 clocks, then high → no strobe; busy returns to 0 within 100 clocks.
  - A following 0x2C is received correctly.
- Framing error and break:
  - 0x47 with the stop bit low → frame_err pulse, no uart_valid, uart_data holds the previous 0x2C.
  - Then rx held low for 3000 clocks → no further strobes.
  - Then rx released and 0x41 sent → uart_valid with 0x41.
- Noise and baud tolerance:
  - 1-clock inverted pulse on rx aligned to an os_cnt=8 sample in every data bit of 0x55 → uart_data=0x55.
  - Transmitter at ±2% baud sending 0xA5 → uart_data=0xA5.
- Reset mid-frame: assert rst during data bit 3 of 0x33 → all outputs 0 and no strobe. After release, 0x31 is received correctly.

Source files
------------

// File: rtl/gps_uart_pkg.sv
// gps_uart_pkg
// Shared types, constants and helpers for the GPS NMEA UART receive path.
// Contents:
//   state_t    - receiver frame state
//   OS_RATE    - oversample ticks per bit
//   SAMPLE_*   - oversample positions used for the 3-point majority vote
//   DATA_BITS  - payload bits per frame (8N1)
//   os_div()   - clocks per oversample tick, rounded to nearest
package gps_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int OS_RATE    = 16;
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_MID = 8;
  localparam int SAMPLE_HI  = 9;
  localparam int DATA_BITS  = 8;

  // Rounded division so the tick period error stays within half a clock.
  function automatic int os_div(input int clk_freq, input int baud);
    return (clk_freq + baud * 8) / (baud * 16);
  endfunction

endpackage

// File: rtl/gps_uart_if.sv
// gps_uart_if
// Byte handshake between the UART receiver and the NMEA sentence parser.
// Signals:
//   uart_data  - last correctly framed byte
//   uart_valid - one-cycle strobe when uart_data is updated
//   frame_err  - one-cycle strobe when a stop bit is sampled low
//   busy       - a frame is in progress
// Modports:
//   master - receiver side (drives everything)
//   slave  - parser side (observes everything)
interface gps_uart_if;

  logic [7:0] uart_data;
  logic       uart_valid;
  logic       frame_err;
  logic       busy;

  modport master (output uart_data, output uart_valid, output frame_err, output busy);
  modport slave  (input  uart_data, input  uart_valid, input  frame_err, input  busy);

endinterface

// File: rtl/gps_uart_os_tick.sv
// gps_uart_os_tick
// Oversample tick generator: divides clk by OS_DIV while not cleared.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   clr  - synchronous clear; holds the divider at 0
//   tick - one-cycle pulse on the last count of each divider period
module gps_uart_os_tick #(
  parameter int OS_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(OS_DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    tick      = !clr && (div_cnt_q == DIV_LAST);
    div_cnt_d = div_cnt_q + CW'(1);
    if (clr || tick) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/gps_uart_rx.sv
// gps_uart_rx
// 8N1 serial receiver for the GPS NMEA path, 16x oversampled with a
// 3-sample majority vote per bit, false-start rejection and stop-bit checking.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   rx   - asynchronous serial input, idle high
//   bus  - gps_uart_if.master: uart_data / uart_valid / frame_err / busy
module gps_uart_rx
  import gps_uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  gps_uart_if.master    bus
);

  localparam int OS_DIV = os_div(CLK_FREQ, BAUD);

  localparam logic [3:0] OS_LO   = 4'(SAMPLE_LO);
  localparam logic [3:0] OS_MID  = 4'(SAMPLE_MID);
  localparam logic [3:0] OS_HI   = 4'(SAMPLE_HI);
  localparam logic [3:0] OS_LAST = 4'(OS_RATE - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  generate
    if (OS_DIV < 2) begin : g_bad_os_div
      $error("gps_uart_rx: OS_DIV must be at least 2");
    end
  endgenerate

  state_t     state_q, state_d;
  logic       rx_meta_q, rx_s_q;
  logic       armed_q, armed_d;
  logic [3:0] os_cnt_q, os_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic [1:0] samp_q, samp_d;
  logic [7:0] uart_data_q, uart_data_d;
  logic       uart_valid_q, uart_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       tick;
  logic       maj;

  // The divider only runs inside a frame, so it restarts from 0 on START entry.
  gps_uart_os_tick #(.OS_DIV(OS_DIV)) u_os_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == IDLE),
    .tick (tick)
  );

  // Majority uses the two stored samples plus the live sample at SAMPLE_HI.
  assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q;
    os_cnt_d     = os_cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    samp_d       = samp_q;
    uart_data_d  = uart_data_q;
    uart_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (tick) begin
      os_cnt_d = os_cnt_q + 4'd1;
      if (os_cnt_q == OS_LO) begin
        samp_d[0] = rx_s_q;
      end
      if (os_cnt_q == OS_MID) begin
        samp_d[1] = rx_s_q;
      end
    end

    case (state_q)
      IDLE: begin
        os_cnt_d = 4'd0;
        // After a framing error the line must go high before a new start counts.
        if (rx_s_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = START;
        end
      end
      START: begin
        if (tick && os_cnt_q == OS_HI && maj) begin
          state_d = IDLE;
        end else if (tick && os_cnt_q == OS_LAST) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (tick && os_cnt_q == OS_HI) begin
          shreg_d = {maj, shreg_q[7:1]};
        end
        if (tick && os_cnt_q == OS_LAST) begin
          if (bit_idx_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        // Leaving at mid stop bit lets the next start edge be caught on time.
        if (tick && os_cnt_q == OS_HI) begin
          state_d = IDLE;
          if (maj) begin
            uart_data_d  = shreg_q;
            uart_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            armed_d     = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= IDLE;
      armed_q      <= 1'b1;
      os_cnt_q     <= 4'd0;
      bit_idx_q    <= 3'd0;
      shreg_q      <= 8'd0;
      samp_q       <= 2'd0;
      uart_data_q  <= 8'd0;
      uart_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      state_q      <= state_d;
      armed_q      <= armed_d;
      os_cnt_q     <= os_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      samp_q       <= samp_d;
      uart_data_q  <= uart_data_d;
      uart_valid_q <= uart_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.uart_data  = uart_data_q;
  assign bus.uart_valid = uart_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_gps_uart_rx.sv
// tb_gps_uart_rx
// Directed plus randomized stimulus for gps_uart_rx at 1.6 MHz / 10 kbaud
// (160 clocks per bit). An 8N1 line model drives rx; a monitor collects
// every strobe so each step can be compared against the bytes the line
// model framed correctly.
module tb_gps_uart_rx;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int BIT_CLKS = 160;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx  = 1'b1;

  always #5 clk = ~clk;

  gps_uart_if bus ();

  gps_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int valid_cyc = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  int wide_cnt = 0;
  logic prev_v = 1'b0;
  logic prev_e = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  // Cycle counter advances on the active edge; everything else reads it on the falling edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: record every delivered byte and any strobe-shape violations.
  always @(negedge clk) begin
    if (bus.uart_valid === 1'b1) begin
      got_q.push_back(bus.uart_data);
      valid_cyc = cyc;
    end
    if (bus.frame_err === 1'b1) ferr_cnt++;
    if (bus.uart_valid === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
    if ((bus.uart_valid === 1'b1 && prev_v) || (bus.frame_err === 1'b1 && prev_e)) wide_cnt++;
    prev_v = (bus.uart_valid === 1'b1);
    prev_e = (bus.frame_err === 1'b1);
  end

  // Hard stop so a stuck bench still reports.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive the first nbits of an 8N1 frame (start, 8 data LSB first, stop).
  // With noise set, one clock of each data bit at the mid sample point is inverted.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit,
                               input int period, input bit noise, input int nbits);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < period; c++) begin
        @(negedge clk);
        if (i == 0 && c == 0) fall_cyc = cyc;
        rx = (noise && i >= 1 && i <= 8 && c == 90) ? ~frame[i] : frame[i];
      end
    end
  endtask

  task automatic idleLine(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  initial begin
    int n0;
    int e0;
    int lat;
    logic [7:0] gpgga [6];
    logic [7:0] rb;

    gpgga = '{8'h24, 8'h47, 8'h50, 8'h47, 8'h47, 8'h41};

    // Reset state
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_data",  int'(bus.uart_data),  0);
    checkOutput("rst_valid", int'(bus.uart_valid), 0);
    checkOutput("rst_ferr",  int'(bus.frame_err),  0);
    checkOutput("rst_busy",  int'(bus.busy),       0);
    rst = 1'b0;
    idleLine(20);

    // Single byte with latency from the falling edge
    n0 = got_q.size();
    applyStimulus(8'h24, 1'b1, BIT_CLKS, 1'b0, 10);
    idleLine(20);
    checkOutput("single_count", got_q.size() - n0, 1);
    if (got_q.size() > n0) checkOutput("single_data", int'(got_q[n0]), 'h24);
    checkOutput("single_ferr", ferr_cnt, 0);
    lat = valid_cyc - fall_cyc;
    checkOutput("single_latency_in_window", int'(lat >= 1540 && lat <= 1544), 1);

    // Back-to-back "$GPGGA" with no idle between frames
    n0 = got_q.size();
    for (int i = 0; i < 6; i++) applyStimulus(gpgga[i], 1'b1, BIT_CLKS, 1'b0, 10);
    idleLine(20);
    checkOutput("b2b_count", got_q.size() - n0, 6);
    for (int i = 0; i < 6; i++) begin
      if (got_q.size() > n0 + i) checkOutput($sformatf("b2b_data%0d", i), int'(got_q[n0 + i]), int'(gpgga[i]));
    end
    checkOutput("b2b_ferr", ferr_cnt, 0);

    // False start: short low pulse must be rejected
    n0 = got_q.size();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    @(negedge clk);
    rx = 1'b1;
    for (int i = 0; i < 100 && bus.busy === 1'b1; i++) @(negedge clk);
    checkOutput("fstart_busy", int'(bus.busy), 0);
    idleLine(50);
    checkOutput("fstart_nostrobe", got_q.size() - n0, 0);
    applyStimulus(8'h2C, 1'b1, BIT_CLKS, 1'b0, 10);
    idleLine(20);
    checkOutput("after_fstart_count", got_q.size() - n0, 1);
    if (got_q.size() > n0) checkOutput("after_fstart_data", int'(got_q[n0]), 'h2C);

    // Framing error followed by a long break
    n0 = got_q.size();
    e0 = ferr_cnt;
    applyStimulus(8'h47, 1'b0, BIT_CLKS, 1'b0, 10);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    checkOutput("ferr_pulses", ferr_cnt - e0, 1);
    checkOutput("ferr_novalid", got_q.size() - n0, 0);
    checkOutput("ferr_data_hold", int'(bus.uart_data), 'h2C);
    idleLine(200);
    applyStimulus(8'h41, 1'b1, BIT_CLKS, 1'b0, 10);
    idleLine(20);
    checkOutput("after_break_ferr", ferr_cnt - e0, 1);
    checkOutput("after_break_count", got_q.size() - n0, 1);
    if (got_q.size() > n0) checkOutput("after_break_data", int'(got_q[n0]), 'h41);

    // Single-clock glitch at the mid sample point of every data bit
    n0 = got_q.size();
    applyStimulus(8'h55, 1'b1, BIT_CLKS, 1'b1, 10);
    idleLine(20);
    checkOutput("noise_count", got_q.size() - n0, 1);
    if (got_q.size() > n0) checkOutput("noise_data", int'(got_q[n0]), 'h55);

    // Transmitter 2% fast and 2% slow
    n0 = got_q.size();
    applyStimulus(8'hA5, 1'b1, 157, 1'b0, 10);
    idleLine(40);
    applyStimulus(8'hA5, 1'b1, 163, 1'b0, 10);
    idleLine(40);
    checkOutput("baud_count", got_q.size() - n0, 2);
    if (got_q.size() > n0)     checkOutput("baud_fast_data", int'(got_q[n0]), 'hA5);
    if (got_q.size() > n0 + 1) checkOutput("baud_slow_data", int'(got_q[n0 + 1]), 'hA5);

    // Reset during data bit 3 of 0x33
    n0 = got_q.size();
    applyStimulus(8'h33, 1'b1, BIT_CLKS, 1'b0, 4);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midrst_data",  int'(bus.uart_data),  0);
    checkOutput("midrst_valid", int'(bus.uart_valid), 0);
    checkOutput("midrst_ferr",  int'(bus.frame_err),  0);
    checkOutput("midrst_busy",  int'(bus.busy),       0);
    rst = 1'b0;
    idleLine(2000);
    checkOutput("midrst_nostrobe", got_q.size() - n0, 0);
    applyStimulus(8'h31, 1'b1, BIT_CLKS, 1'b0, 10);
    idleLine(20);
    checkOutput("after_rst_count", got_q.size() - n0, 1);
    if (got_q.size() > n0) checkOutput("after_rst_data", int'(got_q[n0]), 'h31);

    // Random bytes with random idle gaps, checked against the framed-byte list
    n0 = got_q.size();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom_range(0, 255));
      exp_q.push_back(rb);
      idleLine($urandom_range(0, 30));
      applyStimulus(rb, 1'b1, BIT_CLKS, 1'b0, 10);
    end
    idleLine(40);
    checkOutput("rand_count", got_q.size() - n0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (got_q.size() > n0 + i) checkOutput($sformatf("rand_data%0d", i), int'(got_q[n0 + i]), int'(exp_q[i]));
    end

    // Strobe shape over the whole run
    checkOutput("strobe_overlap", both_cnt, 0);
    checkOutput("strobe_width", wide_cnt, 0);
    checkOutput("total_ferr", ferr_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
